// File: rtl/conv_writer_pkg.sv
// rtl/conv_writer_pkg.sv - shared types and constants for the convolution result writer
package conv_writer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2,
    ST_DONE = 2'd3
  } wr_state_e;

  localparam int DEF_TOTAL_WORDS = 3136 * 16;
  localparam int DEF_ADDR_STEP   = 4;
  // Free slots needed to keep bus_free high: registered-flag lag plus one word in flight.
  localparam int FREE_MARGIN     = 3;

  function automatic logic [31:0] relu32(input logic [31:0] w);
    return w[31] ? 32'd0 : w;
  endfunction

endpackage

// File: rtl/conv_result_writer_fifo.sv
// rtl/conv_result_writer_fifo.sv - result_fifo: synchronous FIFO with flush, full/empty/count
module result_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         pop_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign pop_data_o = mem_q[rd_ptr_q];

  // A push into a full FIFO is legal when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/conv_result_writer.sv
// rtl/conv_result_writer.sv - buffers accumulator results and writes them to memory over a single-master bus
// Optional ReLU clamp on incoming words: CONV_WRITER_RELU_EN.
module conv_result_writer
  import conv_writer_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int TOTAL_WORDS = DEF_TOTAL_WORDS,
  parameter int ADDR_STEP   = DEF_ADDR_STEP
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [31:0] cfg_base_i,
  input  logic        valid_i,
  input  logic [31:0] data_i,
  input  logic        conv_done_i,
  output logic        bus_free,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  output logic        done_o,
  output logic        overflow_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FREE_LIMIT = (AW+1)'(FIFO_DEPTH - FREE_MARGIN);

  wr_state_e   state_q, state_d;
  logic        armed_q, armed_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] word_cnt_q, word_cnt_d;
  logic        overflow_q, overflow_d;
  logic        bus_free_q, bus_free_d;

  logic        fifo_full, fifo_empty;
  logic [AW:0] fifo_count, count_nxt;
  logic [31:0] fifo_head, push_data;
  logic        accept, push, pop, drop, last_word;

  // Completion is by word count alone; the upstream done flag is informational.
  wire unused_conv_done = conv_done_i;

`ifdef CONV_WRITER_RELU_EN
  assign push_data = relu32(data_i);
`else
  assign push_data = data_i;
`endif

  assign accept    = armed_q && (state_q != ST_DONE) && !start_i;
  assign pop       = (state_q == ST_XFER) && bus_ready && !start_i;
  assign push      = valid_i && accept && (!fifo_full || pop);
  assign drop      = valid_i && accept && fifo_full && !pop;
  assign last_word = (word_cnt_q + 32'd1) == 32'(TOTAL_WORDS);

  result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (start_i),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .pop_data_o  (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  always_comb begin
    count_nxt = fifo_count;
    if (start_i) begin
      count_nxt = '0;
    end else begin
      if (push) count_nxt = count_nxt + (AW+1)'(1);
      if (pop)  count_nxt = count_nxt - (AW+1)'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    armed_d    = armed_q;
    addr_d     = addr_q;
    word_cnt_d = word_cnt_q;
    overflow_d = overflow_q || drop;
    if (start_i) begin
      state_d    = ST_IDLE;
      armed_d    = 1'b1;
      addr_d     = cfg_base_i;
      word_cnt_d = '0;
      overflow_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (armed_q && !fifo_empty) state_d = ST_REQ;
        ST_REQ:  if (bus_gnt) state_d = ST_XFER;
        ST_XFER: begin
          if (bus_ready) begin
            addr_d     = addr_q + 32'(ADDR_STEP);
            word_cnt_d = word_cnt_q + 32'd1;
            if (last_word)                         state_d = ST_DONE;
            else if ((count_nxt != '0) && bus_gnt) state_d = ST_XFER;
            else                                   state_d = ST_IDLE;
          end else if (!bus_gnt) begin
            // Grant lost before acceptance: re-arbitrate and reissue the same word.
            state_d = ST_REQ;
          end
        end
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end
    bus_free_d = armed_d && (state_d != ST_DONE) && (count_nxt <= FREE_LIMIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      armed_q    <= 1'b0;
      addr_q     <= '0;
      word_cnt_q <= '0;
      overflow_q <= 1'b0;
      bus_free_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      armed_q    <= armed_d;
      addr_q     <= addr_d;
      word_cnt_q <= word_cnt_d;
      overflow_q <= overflow_d;
      bus_free_q <= bus_free_d;
    end
  end

  assign bus_req    = (state_q == ST_REQ) || (state_q == ST_XFER);
  assign bus_we     = (state_q == ST_XFER);
  assign bus_addr   = bus_we ? addr_q : 32'd0;
  assign bus_wdata  = bus_we ? fifo_head : 32'd0;
  assign done_o     = (state_q == ST_DONE);
  assign overflow_o = overflow_q;
  assign bus_free   = bus_free_q;

endmodule
